// File: rtl/optical_flow_sequencer_if.sv
// Control/status bundle between the flow pipeline top level and its frame sequencer.
// master drives the requests, slave is the sequencer side.
interface optical_flow_sequencer_if #(
   parameter int FRAME_CNT_WIDTH = 16
);
   logic                       start;
   logic                       abort;
   logic                       fb_frame_done;
   logic                       flow_valid_in;
   logic                       fb_start;
   logic                       busy;
   logic                       done;
   logic [9:0]                 flow_x;
   logic [8:0]                 flow_y;
   logic                       coord_valid;
   logic [FRAME_CNT_WIDTH-1:0] frame_count;
   logic                       error_overrun;
   logic                       error_timeout;

   modport master (
      output start, abort, fb_frame_done, flow_valid_in,
      input  fb_start, busy, done, flow_x, flow_y, coord_valid,
      input  frame_count, error_overrun, error_timeout
   );

   modport slave (
      input  start, abort, fb_frame_done, flow_valid_in,
      output fb_start, busy, done, flow_x, flow_y, coord_valid,
      output frame_count, error_overrun, error_timeout
   );
endinterface

// File: rtl/optical_flow_sequencer.sv
// Frame-level Lucas-Kanade sequencer: launch, beat-to-coordinate mapping, drain, done.
// Define FLOW_SEQ_TIMEOUT_EN to build the drain watchdog (error_timeout).
module optical_flow_sequencer #(
   parameter int IMAGE_WIDTH     = 320,
   parameter int IMAGE_HEIGHT    = 240,
   parameter int BORDER          = 3,
   parameter int DRAIN_TIMEOUT   = 4096,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   optical_flow_sequencer_if.slave   bus
);
   localparam int OUT_W    = IMAGE_WIDTH - 2*BORDER;
   localparam int OUT_H    = IMAGE_HEIGHT - 2*BORDER;
   localparam int EXPECTED = OUT_W * OUT_H;
   localparam int BW       = $clog2(EXPECTED + 1);
   localparam logic [9:0] BX = 10'(BORDER);
   localparam logic [8:0] BY = 9'(BORDER);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                     state;
   logic                       fb_start_r;
   logic                       busy_r;
   logic                       done_r;
   logic                       ovr_r;
   logic [9:0]                 col;
   logic [8:0]                 row;
   logic [9:0]                 flow_x_r;
   logic [8:0]                 flow_y_r;
   logic [BW-1:0]              beat_cnt;
   logic                       fb_done_flag;
   logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

   logic          counting;
   logic          full;
   logic          take;
   logic          fd_seen;
   logic          launch;
   logic          wd_fire;
   logic [BW-1:0] beat_next;
   logic [9:0]    col_nx;
   logic [8:0]    row_nx;

   assign counting  = (state == S_STREAM) || (state == S_DRAIN);
   assign full      = (beat_cnt == BW'(EXPECTED));
   assign take      = counting && bus.flow_valid_in && !full;
   assign beat_next = beat_cnt + BW'(take);
   assign fd_seen   = fb_done_flag || bus.fb_frame_done;
   assign launch    = (state == S_IDLE) && bus.start && !bus.abort;

   // Raster walk over the output grid; parks on the last pixel.
   always_comb begin
      col_nx = col;
      row_nx = row;
      if (col == 10'(OUT_W - 1)) begin
         if (row != 9'(OUT_H - 1)) begin
            col_nx = '0;
            row_nx = row + 9'd1;
         end
      end else begin
         col_nx = col + 10'd1;
      end
   end

`ifdef FLOW_SEQ_TIMEOUT_EN
   localparam int WW = $clog2(DRAIN_TIMEOUT + 1);

   logic [WW-1:0] wd;
   logic          tmo_r;

   assign wd_fire = (state == S_DRAIN) && !bus.flow_valid_in &&
                    (wd == WW'(DRAIN_TIMEOUT - 1));

   // wd is held at zero outside DRAIN, so entry always starts a fresh count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd    <= '0;
         tmo_r <= 1'b0;
      end else begin
         if (launch)
            tmo_r <= 1'b0;
         else if (wd_fire && !bus.abort)
            tmo_r <= 1'b1;
         if (state != S_DRAIN || bus.flow_valid_in)
            wd <= '0;
         else
            wd <= wd + WW'(1);
      end
   end

   assign bus.error_timeout = tmo_r;
`else
   assign wd_fire           = 1'b0;
   assign bus.error_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         fb_start_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         ovr_r        <= 1'b0;
         col          <= '0;
         row          <= '0;
         flow_x_r     <= '0;
         flow_y_r     <= '0;
         beat_cnt     <= '0;
         fb_done_flag <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         fb_start_r <= 1'b0;
         done_r     <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (launch) begin
                  state        <= S_LAUNCH;
                  fb_start_r   <= 1'b1;
                  busy_r       <= 1'b1;
                  ovr_r        <= 1'b0;
                  col          <= '0;
                  row          <= '0;
                  flow_x_r     <= BX;
                  flow_y_r     <= BY;
                  beat_cnt     <= '0;
                  fb_done_flag <= 1'b0;
               end
            end
            S_LAUNCH: begin
               if (bus.abort) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end else begin
                  state <= S_STREAM;
               end
            end
            S_STREAM, S_DRAIN: begin
               if (bus.flow_valid_in && full)
                  ovr_r <= 1'b1;
               if (take) begin
                  beat_cnt <= beat_next;
                  col      <= col_nx;
                  row      <= row_nx;
                  flow_x_r <= BX + col_nx;
                  flow_y_r <= BY + row_nx;
               end
               if (bus.fb_frame_done)
                  fb_done_flag <= 1'b1;
               if (bus.abort) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end else if ((fd_seen && beat_next == BW'(EXPECTED)) || wd_fire) begin
                  state     <= S_DONE;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
               end else if (state == S_STREAM && bus.fb_frame_done) begin
                  state <= S_DRAIN;
               end
            end
            S_DONE: state <= S_IDLE;
            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fb_start      = fb_start_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.flow_x        = flow_x_r;
   assign bus.flow_y        = flow_y_r;
   assign bus.coord_valid   = counting && bus.flow_valid_in;
   assign bus.frame_count   = frame_cnt;
   assign bus.error_overrun = ovr_r;
endmodule
